program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Boot-time stage directly upstream of the instruction memory. Receives a byte stream (header + program),
//   packs bytes into 32-bit words, writes them into the IMU, and holds the processor in clear until done.
// - cpu_hold drives the processor clear. imu_* drive the IMU write port.
// PARAMETERS
// - ADDR_W     8   IMU address width
// - ADDR_STEP  4   address increment per word; matches the PC's +4 stride
// - BASE_ADDR  0   address of the first loaded word
// - MAX_WORDS  64  largest accepted word count
// PORTS
// - clk          in   1       system clock; all state changes on posedge
// - clr          in   1       reset; asynchronous, active-low (0 = reset)
// - start        in   1       1-cycle pulse that begins a load
// - rx_data      in   8       stream byte
// - rx_valid     in   1       rx_data valid
// - rx_ready     out  1       loader accepts a byte; transfer = rx_valid & rx_ready at posedge
// - imu_wen      out  1       IMU write strobe, 1 cycle per word
// - imu_addr     out  ADDR_W  IMU write address
// - imu_data     out  32      IMU write data
// - cpu_hold     out  1       1 = processor held in clear
// - busy         out  1       load in progress
// - done         out  1       program loaded successfully
// - err          out  1       load aborted
// - words_loaded out  8       count of words written in the current load
// BEHAVIOUR
// - Reset values: cpu_hold=1; all other outputs 0; state IDLE.
// - FSM states: IDLE, HDR, LOAD, WRITE, CSUM, DONE, ERR.
// - IDLE: rx_ready=0. A start pulse moves to HDR.
// - start pulse is also accepted in DONE or ERR: clears done/err/words_loaded, moves to HDR.
// - start is ignored while busy (HDR/LOAD/WRITE/CSUM).
// - HDR: rx_ready=1. The first accepted byte is N, the word count.
//   - N=0 or N>MAX_WORDS -> ERR.
//   - Otherwise latch N and go to LOAD.
// - LOAD: rx_ready=1. Bytes are big-endian: 1st byte -> [31:24], 4th byte -> [7:0].
//   - The 4th accepted byte moves to WRITE.
//   - rx_valid low stalls with no loss of partial word or byte index.
// - WRITE: exactly 1 cycle, entered the cycle after the 4th byte handshake.
//   - rx_ready=0; imu_wen=1.
//   - imu_addr = BASE_ADDR + idx*ADDR_STEP, truncated to ADDR_W (wraps modulo 2^ADDR_W).
//   - imu_data = assembled word.
//   - words_loaded increments.
//   - Next state: LOAD if words_loaded<N, else CSUM or DONE (see CONFIGURATION).
// - imu_wen is 0 in every state except WRITE. imu_addr/imu_data hold their last values otherwise.
// - busy=1 in HDR/LOAD/WRITE/CSUM.
// - cpu_hold=0 only in DONE; the processor starts the cycle after DONE is entered.
// - DONE: done=1, rx_ready=0. ERR: err=1, cpu_hold=1, rx_ready=0.
// - Extra bytes after the final word are not accepted (rx_ready=0).
// - clr asserted mid-load: immediate return to IDLE, partial word discarded, imu_wen forced 0, cpu_hold=1.
// CONFIGURATION
// - Macro PROGRAM_LOADER_CHECKSUM_EN defined:
//   - After the last WRITE, go to CSUM (rx_ready=1).
//   - One byte is accepted and compared with the running XOR of all data bytes (header excluded).
//   - Match -> DONE; mismatch -> ERR.
// - Macro undefined: CSUM state absent; the last WRITE goes directly to DONE.
// STRUCTURE
// - Package loader_pkg holds: typedef enum logic [2:0] loader_state_t; BYTE_W=8; WORD_W=32; BYTES_PER_WORD=4.
// - Sub-module word_assembler holds the 32-bit shift register, 2-bit byte index and word_ready pulse.
//   - Inputs: byte_in, byte_en, flush.
// - The FSM, address counter and checksum stay in program_loader.
// TESTING
// - Load N=2 (bytes 02 12 34 56 78 9A BC DE F0), rx_valid always high:
//   - imu_wen pulses with addr 0x00/data 0x12345678, then addr 0x04/data 0x9ABCDEF0.
//   - done=1, cpu_hold=0.
// - Header byte 00, then a header byte of MAX_WORDS+1:
//   - err=1, cpu_hold=1, no imu_wen pulse in either case.
// - rx_valid deasserted for 5 cycles between bytes 2 and 3 of a word:
//   - the word is still written intact and the address is unchanged.
// - clr pulsed low after 2 bytes of word 1, then restart with N=1 (bytes AA BB CC DD):
//   - single write, addr 0x00, data 0xAABBCCDD.
// - CHECKSUM_EN, N=1, data 01 02 03 04:
//   - checksum byte 04 -> done=1.
//   - checksum byte 05 -> err=1, cpu_hold stays 1.
// - start pulsed during LOAD is ignored. start in DONE:
//   - clears done, reasserts cpu_hold, and a second load succeeds.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic cpu_hold;
        logic done;
        logic err;
    } state_out_t;

    // Status outputs are a pure function of the state; the loader registers
    // this decode of the next state so the outputs come straight from flops.
    function automatic state_out_t decode_outputs(loader_state_t s);
        state_out_t o;
        o = '{rx_ready: 1'b0, busy: 1'b0, cpu_hold: 1'b1, done: 1'b0, err: 1'b0};
        case (s)
            HDR, LOAD, CSUM: begin
                o.rx_ready = 1'b1;
                o.busy     = 1'b1;
            end
            WRITE: o.busy = 1'b1;
            DONE: begin
                o.cpu_hold = 1'b0;
                o.done     = 1'b1;
            end
            ERR:     o.err = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, IMU write port and status bundle of the program loader.
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    import loader_pkg::*;

    logic                start;
    logic [BYTE_W-1:0]   rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                imu_wen;
    logic [ADDR_W-1:0]   imu_addr;
    logic [WORD_W-1:0]   imu_data;
    logic                cpu_hold;
    logic                busy;
    logic                done;
    logic                err;
    logic [7:0]          words_loaded;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imu_wen, imu_addr, imu_data,
        input  cpu_hold, busy, done, err, words_loaded
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imu_wen, imu_addr, imu_data,
        output cpu_hold, busy, done, err, words_loaded
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words; o_word_ready pulses the cycle
// after the fourth byte and o_word holds the finished word until the next one.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [BYTE_W-1:0] i_byte_in,
    input  logic              i_byte_en,
    input  logic              i_flush,
    output logic              o_last_byte,
    output logic              o_word_ready,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_idx;
    logic                     r_word_ready;
    logic [WORD_W-1:0]        r_word;

    assign o_last_byte  = (r_idx == 2'(BYTES_PER_WORD - 1));
    assign o_word_ready = r_word_ready;
    assign o_word       = r_word;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_word_ready <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_ready <= 1'b0;
            if (i_flush) begin
                r_shift <= '0;
                r_idx   <= '0;
            end else if (i_byte_en) begin
                r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte_in};
                r_idx   <= r_idx + 2'd1;
                // Only three bytes are ever buffered; the fourth completes the word directly.
                if (o_last_byte) begin
                    r_word       <= {r_shift, i_byte_in};
                    r_word_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header + byte stream -> 32-bit IMU writes, CPU held until done.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ADDR_STEP = 4,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 64
) (
    input  logic             clk,
    input  logic             clr,
    program_loader_if.slave  bus
);

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    state_out_t        w_out_next;

    logic              r_rx_ready;
    logic              r_busy;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;
    logic [7:0]        r_words;
    logic [7:0]        r_n;
    logic [ADDR_W-1:0] r_addr;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;
`endif

    logic              w_hs;
    logic              w_start_go;
    logic              w_byte_en;
    logic              w_last_byte;
    logic              w_word_ready;
    logic [WORD_W-1:0] w_word;
    logic [ADDR_W-1:0] w_addr_calc;

    assign w_hs        = bus.rx_valid & r_rx_ready;
    assign w_start_go  = bus.start && (r_state inside {IDLE, DONE, ERR});
    assign w_byte_en   = w_hs && (r_state == LOAD);
    // Address wraps naturally by truncation to ADDR_W.
    assign w_addr_calc = ADDR_W'(BASE_ADDR + ADDR_STEP * int'(r_words));

    word_assembler u_asm (
        .clk          (clk),
        .clr          (clr),
        .i_byte_in    (bus.rx_data),
        .i_byte_en    (w_byte_en),
        .i_flush      (w_start_go),
        .o_last_byte  (w_last_byte),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: if (bus.start) w_state_next = HDR;
            HDR: begin
                if (w_hs) begin
                    if (bus.rx_data == '0 || int'(bus.rx_data) > MAX_WORDS)
                        w_state_next = ERR;
                    else
                        w_state_next = LOAD;
                end
            end
            LOAD: if (w_hs && w_last_byte) w_state_next = WRITE;
            // r_words already counts the word being written in this cycle.
            WRITE: begin
                if (r_words < r_n)
                    w_state_next = LOAD;
                else
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    w_state_next = CSUM;
`else
                    w_state_next = DONE;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: if (w_hs) w_state_next = (bus.rx_data == r_csum) ? DONE : ERR;
`endif
            default: w_state_next = IDLE;
        endcase
        w_out_next = decode_outputs(w_state_next);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= IDLE;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
            r_n        <= '0;
            r_addr     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_rx_ready <= w_out_next.rx_ready;
            r_busy     <= w_out_next.busy;
            r_cpu_hold <= w_out_next.cpu_hold;
            r_done     <= w_out_next.done;
            r_err      <= w_out_next.err;
            if (w_start_go) begin
                r_words <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                r_csum  <= '0;
`endif
            end
            if (r_state == HDR && w_hs) r_n <= bus.rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (w_byte_en) r_csum <= r_csum ^ bus.rx_data;
`endif
            if (r_state == LOAD && w_state_next == WRITE) begin
                r_addr  <= w_addr_calc;
                r_words <= r_words + 8'd1;
            end
        end
    end

    assign bus.rx_ready     = r_rx_ready;
    assign bus.imu_wen      = w_word_ready;
    assign bus.imu_addr     = r_addr;
    assign bus.imu_data     = w_word;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed boot scenarios plus random loads.
module tb_program_loader;

    localparam int ADDR_W    = 8;
    localparam int ADDR_STEP = 4;
    localparam int BASE_ADDR = 0;
    localparam int MAX_WORDS = 64;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(ADDR_W)) bus();

    program_loader #(
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (ADDR_STEP),
        .BASE_ADDR (BASE_ADDR),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]       prog [0:255];
    logic [ADDR_W-1:0] got_addr [$];
    logic [31:0]       got_data [$];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_flip;
`endif

    // Every cycle with the write strobe high is one IMU write.
    always @(negedge clk) begin
        if (bus.imu_wen === 1'b1) begin
            got_addr.push_back(bus.imu_addr);
            got_data.push_back(bus.imu_data);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.rx_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        if (!ok) check_val("rx_ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic run_load(input logic [7:0] hdr, input int gap_max, input int stall_at, input bit mid_start);
        bit          hdr_ok;
        bit          exp_done;
        bit          fin;
        int          idx;
        int          exp_writes;
        logic [7:0]  xsum;
        logic [7:0]  byte_v;
        logic [31:0] word;

        hdr_ok = (hdr != 8'd0) && (int'(hdr) <= MAX_WORDS);
        got_addr.delete();
        got_data.delete();

        pulse_start();
        check_val("start_busy",  32'(bus.busy), 32'd1);
        check_val("start_hold",  32'(bus.cpu_hold), 32'd1);
        check_val("start_done",  32'(bus.done), 32'd0);
        check_val("start_err",   32'(bus.err), 32'd0);
        check_val("start_words", 32'(bus.words_loaded), 32'd0);

        send_byte(hdr);
        xsum = 8'd0;
        idx  = 0;
        if (hdr_ok) begin
            for (int w = 0; w < int'(hdr); w++) begin
                word = prog[w];
                for (int b = 0; b < 4; b++) begin
                    byte_v = word[31-8*b -: 8];
                    if (idx == stall_at)
                        idle_cycles(5);
                    else if (gap_max > 0)
                        idle_cycles(int'($urandom_range(0, gap_max)));
                    send_byte(byte_v);
                    xsum = xsum ^ byte_v;
                    if (mid_start && idx == 1) pulse_start();
                    idx++;
                end
            end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (hdr_ok) send_byte(xsum ^ csum_flip);
        exp_done = hdr_ok && (csum_flip == 8'd0);
`else
        exp_done = hdr_ok && (xsum == xsum);
`endif

        fin = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            if (bus.done === 1'b1 || bus.err === 1'b1) fin = 1'b1;
            else @(negedge clk);
        end
        if (!fin) check_val("finish_timeout", 32'(fin), 32'd1);

        exp_writes = hdr_ok ? int'(hdr) : 0;
        check_val("wr_count", 32'(got_addr.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < got_addr.size(); i++) begin
            check_val($sformatf("wr%0d_addr", i), 32'(got_addr[i]),
                      32'((BASE_ADDR + i * ADDR_STEP) % (1 << ADDR_W)));
            check_val($sformatf("wr%0d_data", i), got_data[i], prog[i]);
        end
        check_val("end_done",     32'(bus.done), 32'(exp_done));
        check_val("end_err",      32'(bus.err), 32'(!exp_done));
        check_val("end_hold",     32'(bus.cpu_hold), 32'(!exp_done));
        check_val("end_words",    32'(bus.words_loaded), 32'(exp_writes));
        check_val("end_busy",     32'(bus.busy), 32'd0);
        check_val("end_rx_ready", 32'(bus.rx_ready), 32'd0);
        $display("load hdr=%0d writes=%0d done=%0b err=%0b hold=%0b",
                 hdr, got_addr.size(), bus.done, bus.err, bus.cpu_hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_flip    = 8'h00;
`endif
        idle_cycles(3);

        check_val("rst_hold",     32'(bus.cpu_hold), 32'd1);
        check_val("rst_busy",     32'(bus.busy), 32'd0);
        check_val("rst_done",     32'(bus.done), 32'd0);
        check_val("rst_err",      32'(bus.err), 32'd0);
        check_val("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check_val("rst_wen",      32'(bus.imu_wen), 32'd0);
        check_val("rst_words",    32'(bus.words_loaded), 32'd0);
        check_val("rst_addr",     32'(bus.imu_addr), 32'd0);
        check_val("rst_data",     bus.imu_data, 32'd0);
        clr = 1'b1;
        idle_cycles(2);
        check_val("idle_rx_ready", 32'(bus.rx_ready), 32'd0);

        prog[0] = 32'h12345678;
        prog[1] = 32'h9ABCDEF0;
        run_load(8'd2, 0, -1, 1'b0);

        // Bytes offered after the final word must be refused.
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        idle_cycles(4);
        bus.rx_valid = 1'b0;
        check_val("extra_writes", 32'(got_addr.size()), 32'd2);
        check_val("extra_ready",  32'(bus.rx_ready), 32'd0);
        check_val("extra_done",   32'(bus.done), 32'd1);

        run_load(8'd0, 0, -1, 1'b0);
        run_load(8'(MAX_WORDS + 1), 0, -1, 1'b0);

        prog[0] = 32'hCAFEF00D;
        run_load(8'd1, 0, 2, 1'b0);

        // Asynchronous clear in the middle of the first word.
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_byte(8'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        clr = 1'b0;
        #1;
        check_val("clr_wen",   32'(bus.imu_wen), 32'd0);
        check_val("clr_hold",  32'(bus.cpu_hold), 32'd1);
        check_val("clr_busy",  32'(bus.busy), 32'd0);
        check_val("clr_ready", 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check_val("clr_writes", 32'(got_addr.size()), 32'd0);
        prog[0] = 32'hAABBCCDD;
        run_load(8'd1, 0, -1, 1'b0);

        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        run_load(8'd3, 1, -1, 1'b1);

        for (int i = 0; i < MAX_WORDS; i++) prog[i] = $urandom;
        run_load(8'(MAX_WORDS), 0, -1, 1'b0);

        repeat (6) begin
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            run_load(8'(n), 3, -1, 1'b0);
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        prog[0]   = 32'h01020304;
        csum_flip = 8'h00;
        run_load(8'd1, 0, -1, 1'b0);
        csum_flip = 8'h01;
        run_load(8'd1, 0, -1, 1'b0);
        csum_flip = 8'h00;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
